// File: rtl/apb4_sysinfo.sv
// APB4 system-information slave: lockable ID registers, scratch registers and a
// free-running uptime counter whose upper word is shadowed on each low-word read.
module apb4_sysinfo #(
    parameter logic [31:0] SYS_VAL = 32'h101F_1010,
    parameter logic [31:0] IDL_VAL = 32'hFFFF_2022,
    parameter logic [31:0] IDH_VAL = 32'hFFFF_FFFF,
    parameter int unsigned NUM_SCR = 4,
    parameter int unsigned UPT_W   = 64
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic [7:0]  paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);
    localparam int unsigned SCR_N = (NUM_SCR == 0) ? 1 : NUM_SCR;
    localparam int unsigned SHW_W = UPT_W - 32;

    localparam logic [5:0] IDX_SYS  = 6'd0;
    localparam logic [5:0] IDX_IDL  = 6'd1;
    localparam logic [5:0] IDX_IDH  = 6'd2;
    localparam logic [5:0] IDX_CTRL = 6'd3;
    localparam logic [5:0] IDX_UPTL = 6'd4;
    localparam logic [5:0] IDX_UPTH = 6'd5;
    localparam logic [5:0] IDX_SCR0 = 6'd6;

    logic             whs, rhs;
    logic [5:0]       idx;
    logic             unused_addr;

    logic [31:0]             sys_q, sys_d, idl_q, idl_d, idh_q, idh_d;
    logic [SCR_N-1:0][31:0]  scr_q, scr_d;
    logic                    lock_q, lock_d, upten_q, upten_d;
    logic [UPT_W-1:0]        cnt_q, cnt_d;
    logic [SHW_W-1:0]        shw_q, shw_d;

    assign whs         = psel & penable & pwrite;
    assign rhs         = psel & penable & ~pwrite;
    assign idx         = paddr[7:2];
    assign unused_addr = ^paddr[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return res;
    endfunction

    // Address decode and read mux; scratch slots beyond NUM_SCR stay unmapped.
    logic        hit;
    logic [31:0] rd_val;
    always_comb begin
        hit    = 1'b1;
        rd_val = '0;
        case (idx)
            IDX_SYS:  rd_val = sys_q;
            IDX_IDL:  rd_val = idl_q;
            IDX_IDH:  rd_val = idh_q;
            IDX_CTRL: rd_val = {30'd0, upten_q, lock_q};
            IDX_UPTL: rd_val = cnt_q[31:0];
            IDX_UPTH: rd_val = 32'(shw_q);
            default: begin
                hit = 1'b0;
                for (int k = 0; k < NUM_SCR; k++) begin
                    if (idx == IDX_SCR0 + 6'(k)) begin
                        hit    = 1'b1;
                        rd_val = scr_q[k];
                    end
                end
            end
        endcase
    end

    logic lock_viol, ro_viol, err;
    logic id_wr, ctrl_wr, upt_clr;

    assign lock_viol = whs & lock_q & (idx <= IDX_IDH);
    assign ro_viol   = whs & ((idx == IDX_UPTL) | (idx == IDX_UPTH));
    assign err       = ((whs | rhs) & ~hit) | lock_viol | ro_viol;
    assign id_wr     = whs & ~lock_q;
    assign ctrl_wr   = whs & (idx == IDX_CTRL) & pstrb[0];
    assign upt_clr   = ctrl_wr & pwdata[2];

    // Outputs are forced quiet while reset is held, even mid-access.
    assign pready  = 1'b1;
    assign pslverr = presetn & err;
    assign prdata  = (presetn & rhs & hit) ? rd_val : '0;

    always_comb begin
        sys_d   = sys_q;
        idl_d   = idl_q;
        idh_d   = idh_q;
        scr_d   = scr_q;
        lock_d  = lock_q;
        upten_d = upten_q;
        shw_d   = shw_q;
        cnt_d   = cnt_q;

        if (id_wr && idx == IDX_SYS) sys_d = merge_bytes(sys_q, pwdata, pstrb);
        if (id_wr && idx == IDX_IDL) idl_d = merge_bytes(idl_q, pwdata, pstrb);
        if (id_wr && idx == IDX_IDH) idh_d = merge_bytes(idh_q, pwdata, pstrb);
        for (int k = 0; k < NUM_SCR; k++)
            if (whs && idx == IDX_SCR0 + 6'(k)) scr_d[k] = merge_bytes(scr_q[k], pwdata, pstrb);

        if (ctrl_wr) begin
            lock_d  = lock_q | pwdata[0];
            upten_d = pwdata[1];
        end

        if (rhs && idx == IDX_UPTL) shw_d = cnt_q[UPT_W-1:32];

        if (upt_clr)      cnt_d = '0;
        else if (upten_q) cnt_d = cnt_q + UPT_W'(1);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sys_q   <= SYS_VAL;
            idl_q   <= IDL_VAL;
            idh_q   <= IDH_VAL;
            scr_q   <= '0;
            lock_q  <= 1'b0;
            upten_q <= 1'b1;
            cnt_q   <= '0;
            shw_q   <= '0;
        end else begin
            sys_q   <= sys_d;
            idl_q   <= idl_d;
            idh_q   <= idh_d;
            scr_q   <= scr_d;
            lock_q  <= lock_d;
            upten_q <= upten_d;
            cnt_q   <= cnt_d;
            shw_q   <= shw_d;
        end
    end
endmodule

// File: tb/tb_apb4_sysinfo.sv
// Bench for apb4_sysinfo: directed scenarios plus a randomized run checked
// against a transaction-level register/counter model.
module tb_apb4_sysinfo;
    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [7:0]  paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    apb4_sysinfo dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // One APB transfer (setup + access); starts and ends on a falling edge.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er,
                        output logic se);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        #1 se = pslverr;
        @(negedge pclk); penable = 1'b1;
        #1 rd = prdata; er = pslverr;
        @(negedge pclk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    task automatic test_reset();
        logic [31:0] rd; logic er, se;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h00;
        #3;
        n_cmp++; if (prdata !== 32'h0) begin n_bad++; $display("FAIL rst_prdata got=%h exp=0", prdata); end
        n_cmp++; if (pslverr !== 1'b0) begin n_bad++; $display("FAIL rst_pslverr got=%b exp=0", pslverr); end
        n_cmp++; if (pready !== 1'b1) begin n_bad++; $display("FAIL rst_pready got=%b exp=1", pready); end
        paddr = 8'h40; pwrite = 1'b1; #1;
        n_cmp++; if (pslverr !== 1'b0) begin n_bad++; $display("FAIL rst_unmapped_err got=%b exp=0", pslverr); end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge pclk); presetn = 1'b1;
        xfer(0, 8'h10, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'd1) begin n_bad++; $display("FAIL rst_first_cnt got=%h exp=1", rd); end
        xfer(0, 8'h00, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h101F_1010 || er !== 1'b0) begin n_bad++; $display("FAIL rst_sys got=%h/%b exp=101f1010/0", rd, er); end
        xfer(0, 8'h04, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'hFFFF_2022 || er !== 1'b0) begin n_bad++; $display("FAIL rst_idl got=%h/%b exp=ffff2022/0", rd, er); end
        xfer(0, 8'h08, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'hFFFF_FFFF || er !== 1'b0) begin n_bad++; $display("FAIL rst_idh got=%h/%b exp=ffffffff/0", rd, er); end
        xfer(0, 8'h0C, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL rst_ctrl got=%h exp=2", rd); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic er, se;
        xfer(1, 8'h04, 32'h1234_5678, 4'b0011, rd, er, se);
        xfer(0, 8'h04, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'hFFFF_5678) begin n_bad++; $display("FAIL strb_idl got=%h exp=ffff5678", rd); end
        xfer(1, 8'h1C, 32'hDEAD_BEEF, 4'b1100, rd, er, se);
        xfer(0, 8'h1C, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'hDEAD_0000) begin n_bad++; $display("FAIL strb_scr1 got=%h exp=dead0000", rd); end
    endtask

    task automatic test_lock();
        logic [31:0] rd; logic er, se;
        xfer(1, 8'h0C, 32'h1, 4'hF, rd, er, se);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL lock_set_err got=%b exp=0", er); end
        xfer(1, 8'h00, 32'h0, 4'hF, rd, er, se);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL lock_wr_err got=%b exp=1", er); end
        xfer(0, 8'h00, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h101F_1010) begin n_bad++; $display("FAIL lock_sys got=%h exp=101f1010", rd); end
        xfer(0, 8'h0C, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL lock_ctrl got=%h exp=1", rd); end
        xfer(1, 8'h0C, 32'h2, 4'hF, rd, er, se);
        xfer(0, 8'h0C, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h3) begin n_bad++; $display("FAIL lock_sticky got=%h exp=3", rd); end
        xfer(1, 8'h18, 32'hA5A5_A5A5, 4'hF, rd, er, se);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL lock_scr_err got=%b exp=0", er); end
        xfer(0, 8'h18, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL lock_scr got=%h exp=a5a5a5a5", rd); end
    endtask

    // Back-to-back read handshakes across the 32-bit carry of the counter.
    task automatic test_uptime();
        logic [31:0] rd, r0, r1, r2, r3; logic er, se;
        force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
        #1 release dut.cnt_q;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h10;
        #1 r0 = prdata;
        @(negedge pclk); paddr = 8'h14; #1 r1 = prdata;
        @(negedge pclk); paddr = 8'h10; #1 r2 = prdata;
        @(negedge pclk); paddr = 8'h14; #1 r3 = prdata;
        @(negedge pclk); psel = 1'b0; penable = 1'b0;
        n_cmp++; if (r0 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL upt_l0 got=%h exp=ffffffff", r0); end
        n_cmp++; if (r1 !== 32'h0) begin n_bad++; $display("FAIL upt_h0 got=%h exp=0", r1); end
        n_cmp++; if (r2 !== 32'h1) begin n_bad++; $display("FAIL upt_l1 got=%h exp=1", r2); end
        n_cmp++; if (r3 !== 32'h1) begin n_bad++; $display("FAIL upt_h1 got=%h exp=1", r3); end
        xfer(1, 8'h0C, 32'h6, 4'hF, rd, er, se);
        xfer(0, 8'h14, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL upt_shadow_kept got=%h exp=1", rd); end
        xfer(0, 8'h10, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h3) begin n_bad++; $display("FAIL upt_after_clr got=%h exp=3", rd); end
    endtask

    task automatic test_ctrl();
        logic [31:0] rd; logic er, se;
        xfer(1, 8'h0C, 32'h6, 4'hF, rd, er, se);
        xfer(0, 8'h10, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL ctrl_clr got=%h exp=1", rd); end
        xfer(1, 8'h0C, 32'h4, 4'b1110, rd, er, se);
        xfer(0, 8'h10, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h5) begin n_bad++; $display("FAIL ctrl_nostrb got=%h exp=5", rd); end
        xfer(1, 8'h0C, 32'h4, 4'b0001, rd, er, se);
        xfer(0, 8'h10, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL ctrl_hold got=%h exp=0", rd); end
        xfer(0, 8'h0C, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL ctrl_rd got=%h exp=1", rd); end
        xfer(1, 8'h0C, 32'h2, 4'hF, rd, er, se);
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, se;
        xfer(0, 8'h40, 0, 0, rd, er, se);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL err_unmapped got=%b/%h exp=1/0", er, rd); end
        xfer(1, 8'h10, 32'h1234, 4'hF, rd, er, se);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_wr_uptl got=%b exp=1", er); end
        xfer(1, 8'h14, 32'h1234, 4'hF, rd, er, se);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_wr_upth got=%b exp=1", er); end
        xfer(0, 8'h28, 0, 0, rd, er, se);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL err_scr4 got=%b/%h exp=1/0", er, rd); end
        n_cmp++; if (se !== 1'b0) begin n_bad++; $display("FAIL err_setup got=%b exp=0", se); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd; logic er, se;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h18; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        @(negedge pclk); penable = 1'b1;
        #1 presetn = 1'b0;
        #1;
        n_cmp++; if (pslverr !== 1'b0 || prdata !== 32'h0) begin n_bad++; $display("FAIL midrst_out got=%b/%h exp=0/0", pslverr, prdata); end
        @(negedge pclk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0; presetn = 1'b1;
        xfer(0, 8'h10, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL midrst_cnt got=%h exp=1", rd); end
        xfer(0, 8'h18, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL midrst_scr got=%h exp=0", rd); end
        xfer(0, 8'h0C, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL midrst_ctrl got=%h exp=2", rd); end
        xfer(0, 8'h04, 0, 0, rd, er, se);
        n_cmp++; if (rd !== 32'hFFFF_2022) begin n_bad++; $display("FAIL midrst_idl got=%h exp=ffff2022", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, d, e_rd, m_sys, m_idl, m_idh, m_shw;
        logic [31:0] m_scr [4];
        logic [63:0] m_cnt, cs;
        logic [5:0]  idx;
        logic [3:0]  s;
        logic        er, se, wr, m_lock, m_en, nen, clr, mapped, e_err;
        @(negedge pclk); presetn = 1'b0;
        @(negedge pclk); presetn = 1'b1;
        m_sys = 32'h101F_1010; m_idl = 32'hFFFF_2022; m_idh = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) m_scr[k] = '0;
        m_lock = 1'b0; m_en = 1'b1; m_cnt = '0; m_shw = '0;
        for (int i = 0; i < 250; i++) begin
            idx = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 11));
            wr  = 1'($urandom_range(0, 1));
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            if (idx == 6'd3 && $urandom_range(0, 15) != 0) d[0] = 1'b0;
            cs     = m_cnt + 64'(m_en);
            mapped = (idx <= 6'd5) || (idx >= 6'd6 && idx < 6'd10);
            e_err  = !mapped || (wr && ((idx <= 6'd2 && m_lock) || idx == 6'd4 || idx == 6'd5));
            e_rd   = '0;
            if (!wr && mapped) begin
                case (idx)
                    6'd0: e_rd = m_sys;
                    6'd1: e_rd = m_idl;
                    6'd2: e_rd = m_idh;
                    6'd3: e_rd = {30'd0, m_en, m_lock};
                    6'd4: e_rd = cs[31:0];
                    6'd5: e_rd = m_shw;
                    default: e_rd = m_scr[idx - 6'd6];
                endcase
            end
            xfer(wr, {idx, 2'($urandom_range(0, 3))}, d, s, rd, er, se);
            n_cmp++; if (rd !== e_rd) begin n_bad++; $display("FAIL rnd_rd[%0d] idx=%0d got=%h exp=%h", i, idx, rd, e_rd); end
            n_cmp++; if (er !== e_err) begin n_bad++; $display("FAIL rnd_err[%0d] idx=%0d wr=%b got=%b exp=%b", i, idx, wr, er, e_err); end
            n_cmp++; if (se !== 1'b0) begin n_bad++; $display("FAIL rnd_setup_err[%0d] got=%b exp=0", i, se); end
            clr = 1'b0; nen = m_en;
            if (wr && !e_err) begin
                case (idx)
                    6'd0: m_sys = bmerge(m_sys, d, s);
                    6'd1: m_idl = bmerge(m_idl, d, s);
                    6'd2: m_idh = bmerge(m_idh, d, s);
                    6'd3: if (s[0]) begin m_lock = m_lock | d[0]; nen = d[1]; clr = d[2]; end
                    default: m_scr[idx - 6'd6] = bmerge(m_scr[idx - 6'd6], d, s);
                endcase
            end
            if (!wr && idx == 6'd4) m_shw = cs[63:32];
            m_cnt = clr ? 64'd0 : cs + 64'(m_en);
            m_en  = nen;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_strobe();
        test_lock();
        test_uptime();
        test_ctrl();
        test_errors();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
